// File: rtl/tx_arp_gen.sv
// tx_arp_gen: builds a padded 60-byte Ethernet ARP frame (request/reply)
// and streams it DATA_BYTES per beat over a valid/ready bus.
// Ports:
//   CLK_125M, SYS_RST_N (sync, active low)
//   TRIG_TX_ARP, ARP_OPER, PC_MAC, PC_IP  - trigger and peer fields
//   ARP_DATA, ARP_VALID, ARP_LAST, ARP_READY - beat stream
//   ARP_BUSY, ARP_DONE, ARP_DROP           - status
module tx_arp_gen #(
  parameter logic [47:0] FPGA_MAC   = 48'h00D0_0800_0002,
  parameter logic [31:0] FPGA_IP    = 32'hC0A8_006E,
  parameter int          DATA_BYTES = 1,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                    CLK_125M,
  input  logic                    SYS_RST_N,
  input  logic                    TRIG_TX_ARP,
  input  logic                    ARP_OPER,
  input  logic [47:0]             PC_MAC,
  input  logic [31:0]             PC_IP,
  output logic [8*DATA_BYTES-1:0] ARP_DATA,
  output logic                    ARP_VALID,
  output logic                    ARP_LAST,
  input  logic                    ARP_READY,
  output logic                    ARP_BUSY,
  output logic                    ARP_DONE,
  output logic                    ARP_DROP
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int WORDS = 60 / DATA_BYTES;
  localparam logic [5:0] LAST_BEAT = 6'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_LOAD,
    S_SEND
  } state_t;

  state_t       state_q, state_d;
  logic         q_full_q, q_full_d;
  logic         q_oper_q, q_oper_d;
  logic [47:0]  q_mac_q, q_mac_d;
  logic [31:0]  q_ip_q, q_ip_d;
  logic         c_oper_q, c_oper_d;
  logic [47:0]  c_mac_q, c_mac_d;
  logic [31:0]  c_ip_q, c_ip_d;
  logic [479:0] frame_q, frame_d;
  logic [5:0]   beat_q, beat_d;
  logic         done_q, done_d;
  logic         drop_q, drop_d;

  logic hs, fin, pop;

  // Byte k of the frame lives in bits [8k+7:8k], so each beat is
  // simply the low DW bits and the register shifts right per beat.
  function automatic logic [479:0] build_frame(
    input logic        oper,
    input logic [47:0] mac,
    input logic [31:0] ip
  );
    logic [7:0]   b [60];
    logic [479:0] f;
    f = '0;
    for (int k = 0; k < 6; k++) begin
      b[k]      = oper ? mac[47-8*k -: 8] : 8'hFF;
      b[6+k]    = FPGA_MAC[47-8*k -: 8];
      b[22+k]   = FPGA_MAC[47-8*k -: 8];
      b[32+k]   = oper ? mac[47-8*k -: 8] : 8'h00;
    end
    b[12] = 8'h08;
    b[13] = 8'h06;
    b[14] = 8'h00;
    b[15] = 8'h01;
    b[16] = 8'h08;
    b[17] = 8'h00;
    b[18] = 8'h06;
    b[19] = 8'h04;
    b[20] = 8'h00;
    b[21] = oper ? 8'h02 : 8'h01;
    for (int k = 0; k < 4; k++) begin
      b[28+k] = FPGA_IP[31-8*k -: 8];
      b[38+k] = ip[31-8*k -: 8];
    end
    for (int k = 42; k < 60; k++) begin
      b[k] = PAD_BYTE;
    end
    for (int k = 0; k < 60; k++) begin
      f[8*k +: 8] = b[k];
    end
    return f;
  endfunction

  always_comb begin
    state_d  = state_q;
    q_full_d = q_full_q;
    q_oper_d = q_oper_q;
    q_mac_d  = q_mac_q;
    q_ip_d   = q_ip_q;
    c_oper_d = c_oper_q;
    c_mac_d  = c_mac_q;
    c_ip_d   = c_ip_q;
    frame_d  = frame_q;
    beat_d   = beat_q;
    drop_d   = 1'b0;
    pop      = 1'b0;
    hs       = (state_q == S_SEND) && ARP_READY;
    fin      = hs && (beat_q == LAST_BEAT);
    done_d   = fin;

    unique case (state_q)
      S_IDLE: begin
        if (q_full_q) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_GAP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        frame_d = build_frame(c_oper_q, c_mac_q, c_ip_q);
        beat_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          frame_d = frame_q >> DW;
          beat_d  = beat_q + 6'd1;
        end
        // A queued frame is popped at the final handshake so a
        // trigger landing on that same edge still finds room.
        if (fin) begin
          if (q_full_q) begin
            pop     = 1'b1;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      c_oper_d = q_oper_q;
      c_mac_d  = q_mac_q;
      c_ip_d   = q_ip_q;
      q_full_d = 1'b0;
    end

    if (TRIG_TX_ARP) begin
      if (!q_full_q || pop) begin
        q_full_d = 1'b1;
        q_oper_d = ARP_OPER;
        q_mac_d  = PC_MAC;
        q_ip_d   = PC_IP;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_125M) begin
    if (!SYS_RST_N) begin
      state_q  <= S_IDLE;
      q_full_q <= 1'b0;
      q_oper_q <= 1'b0;
      q_mac_q  <= '0;
      q_ip_q   <= '0;
      c_oper_q <= 1'b0;
      c_mac_q  <= '0;
      c_ip_q   <= '0;
      frame_q  <= '0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_full_q <= q_full_d;
      q_oper_q <= q_oper_d;
      q_mac_q  <= q_mac_d;
      q_ip_q   <= q_ip_d;
      c_oper_q <= c_oper_d;
      c_mac_q  <= c_mac_d;
      c_ip_q   <= c_ip_d;
      frame_q  <= frame_d;
      beat_q   <= beat_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign ARP_VALID = (state_q == S_SEND);
  assign ARP_DATA  = ARP_VALID ? frame_q[DW-1:0] : '0;
  assign ARP_LAST  = ARP_VALID && (beat_q == LAST_BEAT);
  assign ARP_BUSY  = (state_q != S_IDLE) || q_full_q;
  assign ARP_DONE  = done_q;
  assign ARP_DROP  = drop_q;

endmodule

// File: tb/tb_tx_arp_gen.sv
// tb_tx_arp_gen: directed bench for tx_arp_gen with a beat scoreboard.
// Golden frames come from a big-endian field concatenation.
module tb_tx_arp_gen;

  localparam int DB = 2;
  localparam int DW = 8 * DB;
  localparam int WORDS = 60 / DB;
  localparam logic [47:0] FMAC = 48'h00D0_0800_0002;
  localparam logic [31:0] FIP  = 32'hC0A8_006E;
  localparam logic [7:0]  PAD  = 8'h5A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          oper = 1'b0;
  logic          ready = 1'b0;
  logic [47:0]   mac = '0;
  logic [31:0]   ip = '0;
  logic [DW-1:0] data;
  logic          valid, last, busy, done, drop;

  tx_arp_gen #(
    .FPGA_MAC  (FMAC),
    .FPGA_IP   (FIP),
    .DATA_BYTES(DB),
    .PAD_BYTE  (PAD)
  ) dut (
    .CLK_125M   (clk),
    .SYS_RST_N  (rst_n),
    .TRIG_TX_ARP(trig),
    .ARP_OPER   (oper),
    .PC_MAC     (mac),
    .PC_IP      (ip),
    .ARP_DATA   (data),
    .ARP_VALID  (valid),
    .ARP_LAST   (last),
    .ARP_READY  (ready),
    .ARP_BUSY   (busy),
    .ARP_DONE   (done),
    .ARP_DROP   (drop)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int frames = 0;
  int drops = 0;
  bit mon_en = 1'b0;
  bit rand_rdy = 1'b0;
  logic p_valid = 1'b0;
  logic p_hs = 1'b0;
  logic p_fin = 1'b0;
  logic p_last = 1'b0;
  logic [DW-1:0] p_data = '0;

  function automatic void chk(string tag, logic [63:0] obs,
                              logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  function automatic void push_frame(logic op, logic [47:0] m,
                                     logic [31:0] i);
    logic [479:0] be;
    beat_t b;
    be = {op ? m : 48'hFFFF_FFFF_FFFF, FMAC,
          16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
          8'h00, op ? 8'h02 : 8'h01,
          FMAC, FIP, op ? m : 48'h0, i, {18{PAD}}};
    for (int n = 0; n < WORDS; n++) begin
      b.l = (n == WORDS - 1);
      for (int j = 0; j < DB; j++)
        b.d[8*j +: 8] = be[479-8*(n*DB+j) -: 8];
      exp_q.push_back(b);
    end
  endfunction

  function automatic void monitor();
    logic  hs;
    beat_t e;
    if (!mon_en) return;
    hs = valid && ready;
    if (p_valid && !p_fin) chk("no_bubble", valid, 1);
    if (p_valid && !p_hs) begin
      chk("stall_data", data, p_data);
      chk("stall_last", last, p_last);
    end
    chk("done_pulse", done, p_fin);
    if (hs) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_beat observed=%0h expected=none", data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat_data", data, e.d);
        chk("beat_last", last, e.l);
      end
    end
    if (done) frames++;
    if (drop) drops++;
    p_valid = valid;
    p_hs    = hs;
    p_fin   = hs && last;
    p_data  = data;
    p_last  = last;
  endfunction

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic trigger(logic op, logic [47:0] m, logic [31:0] i,
                         bit accepted);
    oper = op;
    mac  = m;
    ip   = i;
    trig = 1'b1;
    if (accepted) push_frame(op, m, i);
    tick();
    trig = 1'b0;
    oper = ~op;
    mac  = 48'({$urandom(), $urandom()});
    ip   = $urandom();
  endtask

  task automatic wait_frames(int target);
    for (int k = 0; k < 600 && frames < target; k++) tick();
    chk("frames_done", frames, target);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_drop"}, drop, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    ready  = 1'b1;
    tick();

    // request, latency, first beat
    trigger(1'b0, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0001, 1'b1);
    chk("t1_busy", busy, 1);
    chk("t1_valid_t1", valid, 0);
    tick();
    chk("t1_valid_t2", valid, 0);
    tick();
    chk("t1_valid_t3", valid, 1);
    chk("t1_beat0", data, 16'hFFFF);
    wait_frames(1);
    chk("t1_busy_end", busy, 0);

    // reply, lane order
    trigger(1'b1, 48'h0011_2233_4455, 32'hC0A8_0009, 1'b1);
    tick();
    tick();
    chk("t2_beat0", data, 16'h1100);
    wait_frames(2);

    // random backpressure
    rand_rdy = 1'b1;
    trigger(1'b0, 48'h1234_5678_9ABC, 32'h0A00_0105, 1'b1);
    wait_frames(3);
    rand_rdy = 1'b0;
    ready = 1'b1;
    tick();

    // queue and drop
    trigger(1'b0, 48'hA1A2_A3A4_A5A6, 32'h0A00_0001, 1'b1);
    repeat (5) tick();
    trigger(1'b1, 48'hB1B2_B3B4_B5B6, 32'h0A00_0002, 1'b1);
    repeat (5) tick();
    trigger(1'b0, 48'hC1C2_C3C4_C5C6, 32'h0A00_0003, 1'b0);
    chk("t4_drop", drop, 1);
    chk("t4_busy", busy, 1);
    wait_frames(5);
    chk("t4_drops", drops, 1);
    chk("t4_busy_end", busy, 0);

    // trigger on the final handshake
    trigger(1'b0, 48'hD1D2_D3D4_D5D6, 32'h0A00_0004, 1'b1);
    repeat (WORDS + 1) tick();
    chk("t5_last_on_bus", last, 1);
    chk("t5_valid_on_bus", valid, 1);
    trigger(1'b1, 48'hE1E2_E3E4_E5E6, 32'h0A00_0005, 1'b1);
    chk("t5_no_drop", drop, 0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 1);
    wait_frames(7);
    chk("t5_drops", drops, 1);

    // reset mid-frame
    trigger(1'b0, 48'hF1F2_F3F4_F5F6, 32'h0A00_0006, 1'b1);
    repeat (22) tick();
    chk("t6_mid_valid", valid, 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all_zero("t6_reset");
    exp_q.delete();
    p_valid = 1'b0;
    p_hs = 1'b0;
    p_fin = 1'b0;
    p_last = 1'b0;
    p_data = '0;
    mon_en = 1'b1;
    repeat (4) tick();
    chk("t6_quiet_valid", valid, 0);
    chk("t6_quiet_busy", busy, 0);
    chk("t6_frames", frames, 7);
    trigger(1'b1, 48'h0102_0304_0506, 32'hC0A8_0101, 1'b1);
    wait_frames(8);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
